// File: rtl/fpga_top_fabric.sv
// Miniature LUT fabric: NUM_PADS 4-input LUTs loaded through one serial config chain.
// Optional PAD_OE_EN macro adds a per-LUT output-enable bit and gfpga_pad_f2a_oe port.
module fpga_top_fabric #(
    parameter int NUM_PADS = 8
) (
    input  logic                clk,
    input  logic                global_reset,
    input  logic                prog_en,
    input  logic                ccff_head,
    output logic                ccff_tail,
    input  logic [NUM_PADS-1:0] gfpga_pad_a2f,
    output logic [NUM_PADS-1:0] gfpga_pad_f2a
`ifdef PAD_OE_EN
    ,
    output logic [NUM_PADS-1:0] gfpga_pad_f2a_oe
`endif
);

    localparam int SEL_W = $clog2(NUM_PADS);
`ifdef PAD_OE_EN
    localparam int LUT_W = 16 + 4*SEL_W + 2;
`else
    localparam int LUT_W = 16 + 4*SEL_W + 1;
`endif
    localparam int CFG_BITS = NUM_PADS * LUT_W;
    localparam int RM_BIT   = 16 + 4*SEL_W;

    // Config memory is deliberately not reset; it only changes while prog_en is high.
    logic [CFG_BITS-1:0] cfg;

    always_ff @(posedge clk) begin
        if (prog_en) begin
            cfg <= {cfg[CFG_BITS-2:0], ccff_head};
        end
    end

    assign ccff_tail = cfg[CFG_BITS-1];

    for (genvar k = 0; k < NUM_PADS; k++) begin : g_lut
        logic [LUT_W-1:0] word;
        logic [15:0]      tt;
        logic [3:0]       lut_in;
        logic             lut_out;
        logic             reg_mode;
        logic             q;

        assign word     = cfg[k*LUT_W +: LUT_W];
        assign tt       = word[15:0];
        assign reg_mode = word[RM_BIT];

        for (genvar j = 0; j < 4; j++) begin : g_sel
            assign lut_in[j] = gfpga_pad_a2f[word[16 + j*SEL_W +: SEL_W]];
        end

        assign lut_out = tt[lut_in];

        // Flop holds during programming so a reconfiguration does not disturb its state.
        always_ff @(posedge clk or posedge global_reset) begin
            if (global_reset) begin
                q <= 1'b0;
            end else if (!prog_en) begin
                q <= lut_out;
            end
        end

        assign gfpga_pad_f2a[k] = !prog_en && (reg_mode ? q : lut_out);

`ifdef PAD_OE_EN
        assign gfpga_pad_f2a_oe[k] = !prog_en && word[LUT_W-1];
`endif
    end

endmodule

// File: tb/tb_fpga_top_fabric.sv
// Randomized and directed bench for fpga_top_fabric against a LUT-level reference model.
module tb_fpga_top_fabric;

    localparam int NP    = 8;
    localparam int SEL_W = 3;
`ifdef PAD_OE_EN
    localparam int LUT_W = 16 + 4*SEL_W + 2;
`else
    localparam int LUT_W = 16 + 4*SEL_W + 1;
`endif
    localparam int CFG_BITS = NP * LUT_W;

    logic          clk = 1'b0;
    logic          global_reset;
    logic          prog_en;
    logic          ccff_head;
    logic          ccff_tail;
    logic [NP-1:0] gfpga_pad_a2f;
    logic [NP-1:0] gfpga_pad_f2a;
`ifdef PAD_OE_EN
    logic [NP-1:0] gfpga_pad_f2a_oe;
`endif

    always #5 clk = ~clk;

    fpga_top_fabric #(.NUM_PADS(NP)) dut (
        .clk             (clk),
        .global_reset    (global_reset),
        .prog_en         (prog_en),
        .ccff_head       (ccff_head),
        .ccff_tail       (ccff_tail),
        .gfpga_pad_a2f   (gfpga_pad_a2f),
        .gfpga_pad_f2a   (gfpga_pad_f2a)
`ifdef PAD_OE_EN
        ,
        .gfpga_pad_f2a_oe(gfpga_pad_f2a_oe)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one record per LUT plus the state of its flop.
    logic [15:0] tt_m [NP];
    int          sel_m[NP][4];
    bit          reg_m[NP];
    bit          oe_m [NP];
    bit          q_m  [NP];
    logic        exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit lut_eval(input int k, input logic [NP-1:0] a);
        int idx;
        idx = 0;
        for (int j = 0; j < 4; j++) begin
            if (a[sel_m[k][j]]) idx += (1 << j);
        end
        return tt_m[k][idx];
    endfunction

    function automatic logic [NP-1:0] exp_f2a();
        logic [NP-1:0] r;
        r = '0;
        for (int k = 0; k < NP; k++) begin
            if (!prog_en) r[k] = reg_m[k] ? q_m[k] : lut_eval(k, gfpga_pad_a2f);
        end
        return r;
    endfunction

    // Bit b of the whole chain, derived from the LUT records.
    function automatic bit cfg_bit(input int b);
        int k, off;
        k   = b / LUT_W;
        off = b % LUT_W;
        if (off < 16) return tt_m[k][off];
        if (off < 16 + 4*SEL_W) return bit'((sel_m[k][(off-16)/SEL_W] >> ((off-16)%SEL_W)) & 1);
        if (off == 16 + 4*SEL_W) return reg_m[k];
        return oe_m[k];
    endfunction

    task automatic check_pads(input string tag);
        check(tag, 32'(gfpga_pad_f2a), 32'(exp_f2a()));
`ifdef PAD_OE_EN
        begin
            logic [NP-1:0] e;
            for (int k = 0; k < NP; k++) e[k] = !prog_en && oe_m[k];
            check({tag, "_oe"}, 32'(gfpga_pad_f2a_oe), 32'(e));
        end
`endif
    endtask

    task automatic tick();
        bit q_next[NP];
        for (int k = 0; k < NP; k++) begin
            q_next[k] = (!global_reset && !prog_en) ? lut_eval(k, gfpga_pad_a2f) : q_m[k];
        end
        @(posedge clk);
        for (int k = 0; k < NP; k++) q_m[k] = global_reset ? 1'b0 : q_next[k];
        #1;
    endtask

    task automatic set_reset(input logic v);
        global_reset = v;
        if (v) begin
            for (int k = 0; k < NP; k++) q_m[k] = 1'b0;
        end
        #1;
    endtask

    task automatic clear_cfg();
        for (int k = 0; k < NP; k++) begin
            tt_m[k] = 16'h0;
            reg_m[k] = 1'b0;
            oe_m[k] = 1'b0;
            for (int j = 0; j < 4; j++) sel_m[k][j] = 0;
        end
    endtask

    task automatic load_cfg();
        prog_en = 1'b1;
        #1;
        check_pads("prog_force");
        for (int b = CFG_BITS - 1; b >= 0; b--) begin
            ccff_head = cfg_bit(b);
            tick();
            if (b % LUT_W == 0) check_pads("prog_shift");
        end
        prog_en   = 1'b0;
        ccff_head = 1'b0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] or_pat [4];
        logic       or_exp [4];
        or_pat = '{2'b00, 2'b10, 2'b01, 2'b11};
        or_exp = '{1'b0, 1'b1, 1'b1, 1'b1};

        global_reset  = 1'b1;
        prog_en       = 1'b1;
        ccff_head     = 1'b0;
        gfpga_pad_a2f = '0;
        for (int k = 0; k < NP; k++) q_m[k] = 1'b0;
        #1;
        check("reset_f2a", 32'(gfpga_pad_f2a), 32'h0);

        // 1-bit OR on LUT0, combinational
        clear_cfg();
        tt_m[0] = 16'hEEEE;
        sel_m[0][1] = 1;
        load_cfg();
        set_reset(1'b0);
        for (int i = 0; i < 4; i++) begin
            gfpga_pad_a2f = NP'(or_pat[i]);
            #1;
            check("or_comb", 32'(gfpga_pad_f2a[0]), 32'(or_exp[i]));
            check_pads("or_all");
        end

        set_reset(1'b1);
        for (int i = 1; i < 4; i++) begin
            gfpga_pad_a2f = NP'(or_pat[4 - i]);
            #1;
            check("or_in_reset", 32'(gfpga_pad_f2a[0]), 32'h1);
            tick();
            check("or_in_reset_edge", 32'(gfpga_pad_f2a[0]), 32'h1);
        end
        set_reset(1'b0);

        // Chain passthrough: a lone 1 arrives at the tail after CFG_BITS clocks
        prog_en = 1'b1;
        ccff_head = 1'b0;
        repeat (CFG_BITS) tick();
        ccff_head = 1'b1;
        tick();
        ccff_head = 1'b0;
        repeat (CFG_BITS - 2) tick();
        check("tail_early", 32'(ccff_tail), 32'h0);
        tick();
        check("tail_arrive", 32'(ccff_tail), 32'h1);
        exp_q.delete();
        for (int i = 0; i < 2 * CFG_BITS; i++) begin
            ccff_head = 1'($urandom_range(0, 1));
            exp_q.push_back(ccff_head);
            tick();
            if (exp_q.size() == CFG_BITS) check("tail_stream", 32'(ccff_tail), 32'(exp_q.pop_front()));
        end
        check_pads("chain_force");

        // Registered OR on LUT0
        clear_cfg();
        tt_m[0] = 16'hEEEE;
        sel_m[0][1] = 1;
        reg_m[0] = 1'b1;
        gfpga_pad_a2f = '0;
        load_cfg();
        tick();
        check("reg_low", 32'(gfpga_pad_f2a[0]), 32'h0);
        gfpga_pad_a2f = NP'(1);
        #1;
        check("reg_before_edge", 32'(gfpga_pad_f2a[0]), 32'h0);
        tick();
        check("reg_after_edge", 32'(gfpga_pad_f2a[0]), 32'h1);
        #2;
        set_reset(1'b1);
        check("reg_rst_now", 32'(gfpga_pad_f2a[0]), 32'h0);
        tick();
        check("reg_rst_hold", 32'(gfpga_pad_f2a[0]), 32'h0);
        set_reset(1'b0);
        check("reg_rel_noedge", 32'(gfpga_pad_f2a[0]), 32'h0);
        tick();
        check("reg_rel_edge", 32'(gfpga_pad_f2a[0]), 32'h1);

        gfpga_pad_a2f = NP'(3);
        prog_en = 1'b1;
        #1;
        check("prog_all_zero", 32'(gfpga_pad_f2a), 32'h0);
        prog_en = 1'b0;
        #1;
        check("prog_release", 32'(gfpga_pad_f2a[0]), 32'h1);
        gfpga_pad_a2f = '0;
        load_cfg();
        check("reg_held", 32'(gfpga_pad_f2a[0]), 32'h1);
        tick();
        check("reg_recapture", 32'(gfpga_pad_f2a[0]), 32'h0);

        // Select coverage: LUT3 buffers the highest pad
        clear_cfg();
        tt_m[3] = 16'hAAAA;
        sel_m[3][0] = NP - 1;
        load_cfg();
        gfpga_pad_a2f = NP'(1) << (NP - 1);
        #1;
        check("sel_hi_one", 32'(gfpga_pad_f2a[3]), 32'h1);
        check_pads("sel_all");
        gfpga_pad_a2f = ~(NP'(1) << (NP - 1));
        #1;
        check("sel_hi_zero", 32'(gfpga_pad_f2a[3]), 32'h0);
        check_pads("sel_all");

        // Random configurations and pad traffic
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NP; k++) begin
                tt_m[k]  = 16'($urandom);
                reg_m[k] = 1'($urandom_range(0, 1));
                oe_m[k]  = 1'($urandom_range(0, 1));
                for (int j = 0; j < 4; j++) sel_m[k][j] = $urandom_range(0, NP - 1);
            end
            load_cfg();
            for (int i = 0; i < 40; i++) begin
                gfpga_pad_a2f = NP'($urandom);
                if ($urandom_range(0, 9) == 0) set_reset(1'b1);
                else if (global_reset && $urandom_range(0, 2) == 0) set_reset(1'b0);
                #1;
                check_pads("rnd_comb");
                tick();
                check_pads("rnd_edge");
            end
            set_reset(1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
